// File: rtl/rsdec_syn_ctrl.sv
// Sequencing controller for the rsdec_syn syndrome generator: symbol intake, serial drain, error flag.
// Optional error-codeword counter built when RSDEC_SYN_CTRL_ERRCNT_EN is defined.
module rsdec_syn_ctrl #(
    parameter int unsigned N    = 255,
    parameter int unsigned NSYN = 6
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        abort,
    output logic [7:0]  syn_u,
    output logic        syn_init,
    output logic        syn_enable,
    output logic        syn_shift,
    input  logic [7:0]  syn_y0,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [2:0]  out_idx,
    output logic        out_last,
    input  logic        out_ready,
    output logic        done,
    output logic        err_flag,
    output logic [15:0] err_cnt
);

    localparam int unsigned CW = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned EW = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  sym_cnt;
    logic [IW-1:0]  idx_q;
    logic           nz;
    logic           done_q;
    logic           err_flag_q;
    logic           in_fire;
    logic           out_fire;
    logic           last_sym;
    logic           last_beat;
    logic           nz_final;

    assign in_ready  = (state != DRAIN);
    assign out_valid = (state == DRAIN);
    assign in_fire   = in_valid & in_ready & ~abort;
    assign out_fire  = out_valid & out_ready & ~abort;
    assign last_sym  = (sym_cnt == CW'(N - 1));
    assign last_beat = (idx_q == IW'(NSYN - 1));
    assign nz_final  = nz | (|syn_y0);

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; abort wins in every state
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_fire) state_nxt = ACCUM;
                ACCUM:   if (in_fire && last_sym) state_nxt = DRAIN;
                DRAIN:   if (out_fire && last_beat) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Generator control pulses, mutually exclusive by state
    always_comb begin
        syn_init   = 1'b0;
        syn_enable = 1'b0;
        syn_shift  = 1'b0;
        case (state)
            IDLE:    syn_init   = in_fire;
            ACCUM:   syn_enable = in_fire;
            DRAIN:   syn_shift  = out_fire;
            default: ;
        endcase
    end

    // Symbol/beat counters and per-codeword nonzero tracking
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sym_cnt    <= '0;
            idx_q      <= '0;
            nz         <= 1'b0;
            done_q     <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (syn_init) begin
                sym_cnt <= CW'(1);
            end else if (syn_enable) begin
                sym_cnt <= sym_cnt + CW'(1);
                if (last_sym) begin
                    idx_q <= '0;
                    nz    <= 1'b0;
                end
            end
            if (syn_shift) begin
                idx_q <= idx_q + IW'(1);
                nz    <= nz_final;
                if (last_beat) begin
                    done_q     <= 1'b1;
                    err_flag_q <= nz_final;
                end
            end
        end
    end

`ifdef RSDEC_SYN_CTRL_ERRCNT_EN
    logic [EW-1:0] err_cnt_q;

    // Saturating count of codewords that finished with a nonzero syndrome
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_cnt_q <= '0;
        end else if (syn_shift && last_beat && nz_final && (err_cnt_q != {EW{1'b1}})) begin
            err_cnt_q <= err_cnt_q + EW'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = EW'(0);
`endif

    assign syn_u    = in_data;
    assign out_data = syn_y0;
    assign out_idx  = idx_q;
    assign out_last = out_valid & last_beat;
    assign done     = done_q;
    assign err_flag = err_flag_q;

endmodule
